// File: rtl/pipeline_controller.sv
// Run/halt/single-step sequencing and hazard control for the 5-stage 8-bit pipeline.
// Drives PC/IF/ID enables, bubble and flush controls, and keeps cycle/stall/flush statistics.
module pipeline_controller #(
  parameter int unsigned LOAD_USE_STALLS = 1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_rt,
  input  logic             MEM_branch_taken,
  output logic             pipe_en,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [31:0]      cycle_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Bubbles still owed after the first one; LOAD_USE_STALLS is at most 7.
  localparam logic [2:0] StallReload = 3'(LOAD_USE_STALLS - 1);

  typedef enum logic [1:0] {
    StHalt = 2'b00,
    StRun  = 2'b01,
    StStep = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       stall_q, stall_d;
  logic             step_q;
  logic [31:0]      cycle_q, cycle_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic advance;
  logic hazard;
  logic step_rise;

  assign advance   = (state_q == StRun) || (state_q == StStep);
  assign step_rise = step & ~step_q;
  assign hazard    = EX_MemRead && (EX_rt != 5'd0) &&
                     ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHalt: begin
        if (run)            state_d = StRun;
        else if (step_rise) state_d = StStep;
      end
      StRun:   if (halt_req) state_d = StHalt;
      StStep:  state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  always_comb begin
    pipe_en     = 1'b0;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    stall_d     = stall_q;
    cycle_d     = cycle_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (advance) begin
      pipe_en = 1'b1;
      cycle_d = cycle_q + 32'd1;
      if (MEM_branch_taken) begin
        // A taken branch squashes the stalled instruction, so any owed bubbles are dropped.
        pc_write    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        stall_d     = 3'd0;
        if (~&flush_cnt_q) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else if ((stall_q != 3'd0) || hazard) begin
        idex_flush = 1'b1;
        stall_d    = (stall_q != 3'd0) ? stall_q - 3'd1 : StallReload;
        if (~&stall_cnt_q) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StHalt;
      stall_q     <= 3'd0;
      step_q      <= 1'b0;
      cycle_q     <= 32'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_q     <= stall_d;
      step_q      <= step;
      cycle_q     <= cycle_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted      = (state_q == StHalt);
  assign cycle_count = cycle_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule
